// File: rtl/add_pkg.sv
// Shared constants for the add_all ripple-carry adder slice.
// Width of a plain instance defaults to the classic 1-bit full adder.
package add_pkg;
    localparam int WIDTH_DEFAULT = 1;
endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell: s = a ^ b ^ cin, cout = majority(a, b, cin).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs always follow the inputs.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/add_all.sv
// WIDTH-bit ripple-carry adder {carry, sum} = a + b + c, plus registered copies.
// Latency: sum/carry are combinational; sum_q/carry_q trail them by exactly one clk edge.
// Backpressure: none; there is no enable or handshake, and a new result is captured every cycle.
module add_all
    import add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q
);
    if (WIDTH < 1) begin : g_width_check
        $error("add_all: WIDTH must be at least 1");
    end

    // k[i] is the carry into bit i; k[WIDTH] is the carry-out and doubles as the overflow flag.
    logic [WIDTH:0] k;

    assign k[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (k[i]),
            .s    (sum[i]),
            .cout (k[i+1])
        );
    end

    assign carry = k[WIDTH];

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    always_comb begin
        sum_d   = sum;
        carry_d = carry;
    end

    // Reset only clears the registered copies; the combinational result keeps tracking the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end
endmodule

// File: tb/tb_add_all.sv
// Directed bench for add_all at WIDTH=1 and WIDTH=4 sharing one clock and reset.
module tb_add_all;
    logic       clk;
    logic       rst_n;

    logic       a1, b1, c1;
    logic       sum1, carry1, sum1_q, carry1_q;

    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] sum4, sum4_q;
    logic       carry4, carry4_q;

    int n_cmp = 0;
    int n_err = 0;

    add_all #(.WIDTH(1)) u_dut1 (
        .sum     (sum1),
        .carry   (carry1),
        .a       (a1),
        .b       (b1),
        .c       (c1),
        .clk     (clk),
        .rst_n   (rst_n),
        .sum_q   (sum1_q),
        .carry_q (carry1_q)
    );

    add_all #(.WIDTH(4)) u_dut4 (
        .sum     (sum4),
        .carry   (carry4),
        .a       (a4),
        .b       (b4),
        .c       (c4),
        .clk     (clk),
        .rst_n   (rst_n),
        .sum_q   (sum4_q),
        .carry_q (carry4_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-written truth table, bit i for {c,b,a} = i.
    logic [7:0] tt_sum;
    logic [7:0] tt_carry;

    // Directed WIDTH=4 vectors: a, b, c, expected sum, expected carry.
    logic [3:0] v_a   [3] = '{4'hF, 4'h5, 4'h3};
    logic [3:0] v_b   [3] = '{4'h1, 4'hA, 4'h4};
    logic       v_c   [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] v_sum [3] = '{4'h0, 4'h0, 4'h7};
    logic       v_cy  [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] ref5;
        tt_sum   = 8'b1001_0110;
        tt_carry = 8'b1110_1000;

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
        #2;
        check_eq("rst_sum1_q",   32'(sum1_q),   32'h0);
        check_eq("rst_carry1_q", 32'(carry1_q), 32'h0);
        check_eq("rst_sum4_q",   32'(sum4_q),   32'h0);
        check_eq("rst_carry4_q", 32'(carry4_q), 32'h0);

        // Truth table, 10 ns apart, with reset held (combinational path must ignore it).
        for (int i = 0; i < 8; i++) begin
            {c1, b1, a1} = 3'(i);
            #1;
            check_eq($sformatf("tt_sum_%0d", i),   32'(sum1),   32'(tt_sum[i]));
            check_eq($sformatf("tt_carry_%0d", i), 32'(carry1), 32'(tt_carry[i]));
            #9;
        end

        // Reset held with all inputs high.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        @(posedge clk); #1;
        check_eq("rsthold_sum_q",   32'(sum1_q),   32'h0);
        check_eq("rsthold_carry_q", 32'(carry1_q), 32'h0);
        check_eq("rsthold_sum",     32'(sum1),     32'h1);
        check_eq("rsthold_carry",   32'(carry1),   32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_before_edge_sum_q", 32'(sum1_q), 32'h0);
        @(posedge clk); #1;
        check_eq("rel_first_edge_sum_q",   32'(sum1_q),   32'h1);
        check_eq("rel_first_edge_carry_q", 32'(carry1_q), 32'h1);

        // Latency: capture 0+0+0, then switch to a=1 just after an edge.
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        check_eq("lat_zero_sum_q", 32'(sum1_q), 32'h0);
        a1 = 1'b1;
        #1;
        check_eq("lat_comb_sum",   32'(sum1),   32'h1);
        check_eq("lat_old_sum_q",  32'(sum1_q), 32'h0);
        @(posedge clk); #1;
        check_eq("lat_new_sum_q",   32'(sum1_q),   32'h1);
        check_eq("lat_new_carry_q", 32'(carry1_q), 32'h0);

        // Async reset between edges: both instances hold nonzero registered values first.
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        a4 = 4'h9; b4 = 4'h9; c4 = 1'b0;
        @(posedge clk); #2;
        check_eq("pre_arst_carry1_q", 32'(carry1_q), 32'h1);
        check_eq("pre_arst_sum4_q",   32'(sum4_q),   32'h2);
        rst_n = 1'b0;
        #1;
        check_eq("arst_sum1_q",   32'(sum1_q),   32'h0);
        check_eq("arst_carry1_q", 32'(carry1_q), 32'h0);
        check_eq("arst_sum4_q",   32'(sum4_q),   32'h0);
        check_eq("arst_carry4_q", 32'(carry4_q), 32'h0);
        check_eq("arst_carry1",   32'(carry1),   32'h1);
        check_eq("arst_sum4",     32'(sum4),     32'h2);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=4 directed vectors including the overflow cases.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a4 = v_a[i]; b4 = v_b[i]; c4 = v_c[i];
            #1;
            check_eq($sformatf("w4_sum_%0d", i),   32'(sum4),   32'(v_sum[i]));
            check_eq($sformatf("w4_carry_%0d", i), 32'(carry4), 32'(v_cy[i]));
            @(posedge clk); #1;
            check_eq($sformatf("w4_sum_q_%0d", i),   32'(sum4_q),   32'(v_sum[i]));
            check_eq($sformatf("w4_carry_q_%0d", i), 32'(carry4_q), 32'(v_cy[i]));
        end

        // All-ones with carry-in: sum all ones, carry set.
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        #1;
        check_eq("w4_ovf_sum",   32'(sum4),   32'hF);
        check_eq("w4_ovf_carry", 32'(carry4), 32'h1);

        // Exhaustive WIDTH=4 sweep on both paths.
        for (int v = 0; v < 512; v++) begin
            @(posedge clk); #1;
            {c4, b4, a4} = 9'(v);
            ref5 = 5'(a4) + 5'(b4) + 5'(c4);
            #1;
            check_eq($sformatf("sweep_comb_%0d", v), 32'({carry4, sum4}), 32'(ref5));
            @(posedge clk); #1;
            check_eq($sformatf("sweep_reg_%0d", v), 32'({carry4_q, sum4_q}), 32'(ref5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
